fsk_rx_sequencer: RTL and testbench
===================================

# fsk_rx_sequencer

Receive-path controller for the FSK demodulator. It gates the sample clock generator through that generator's active-high reset and counts the generator's SAMP pulses. It hunts for a sync word in the demodulated bit stream and frames a fixed-length payload into bytes. Each byte is delivered through a one-entry valid/ready output register.

## Interface
- SYNC_WORD, 16'h2DD4: sync pattern, MSB received first.
- SYNC_LEN, 16: sync pattern length in bits, 1..16; the low SYNC_LEN bits of SYNC_WORD are compared.
- PAYLOAD_BYTES, 4: bytes framed after sync, 1..255.
- HUNT_TIMEOUT, 1024: SAMP pulses allowed in HUNT; 0 disables the timeout.

- CLOCK  in  1  system clock, all logic on posedge
- RESET_N  in  1  synchronous, active-low reset
- ENABLE  in  1  level; start a hunt when high in IDLE
- ABORT  in  1  return to IDLE from any state
- SAMP  in  1  one-cycle sample pulse from the sample clock generator
- BIT_IN  in  1  demodulated bit, valid when SAMP=1
- GEN_RESET  out  1  drives the generator's RESET; 1 holds it stopped
- DATA  out  8  assembled byte
- DATA_VALID  out  1  DATA holds an unconsumed byte
- DATA_READY  in  1  consumer accepts DATA
- BUSY  out  1  state != IDLE
- SYNC_FOUND  out  1  one-cycle pulse on sync match
- TIMEOUT  out  1  one-cycle pulse on hunt timeout
- OVERRUN  out  1  sticky; a byte was dropped
- STATE  out  2  current state code

## Operation
- States: IDLE=0, HUNT=1, FRAME=2, DRAIN=3.
- **IDLE**
  - GEN_RESET=1.
  - SAMP is ignored.
  - ENABLE=1 → HUNT.
  - Entering HUNT clears OVERRUN, the sync shift register, the hunt bit count and the timeout counter.
- **HUNT**
  - GEN_RESET=0.
  - On each SAMP: shift register ← {sr[14:0], BIT_IN}; hunt bit count saturates at SYNC_LEN; timeout counter increments.
  - Match = hunt bit count ≥ SYNC_LEN and the post-shift low SYNC_LEN bits equal SYNC_WORD. On match: SYNC_FOUND pulse → FRAME, with bit and byte counters cleared.
  - Timeout counter reaching HUNT_TIMEOUT without a match: TIMEOUT pulse → IDLE.
  - Match and timeout on the same SAMP: match wins.
- **FRAME**
  - Bits are assembled MSB first.
  - On the 8th bit, the byte is offered to the output register and the byte counter increments.
  - If the byte counter reaches PAYLOAD_BYTES → DRAIN.
- **Output register**
  - Loads if empty, or if a transfer (DATA_VALID & DATA_READY) occurs in the same cycle.
  - Otherwise the new byte is dropped, the old byte is kept, and OVERRUN is set.
  - DATA is stable while DATA_VALID=1.
  - DATA_VALID clears on a transfer with no simultaneous load.
- **DRAIN**
  - GEN_RESET=1; SAMP ignored.
  - → IDLE once DATA_VALID=0.
  - If ENABLE is still high, IDLE re-arms into HUNT on the following cycle.
- **ABORT** (any state other than IDLE)
  - → IDLE next cycle; GEN_RESET=1; DATA_VALID cleared.
  - OVERRUN keeps its value.
  - ABORT has priority over every other transition.
- Counter widths: bit counter 3 bits, byte counter 8 bits, timeout counter $clog2(HUNT_TIMEOUT+1) bits, minimum 1.

## Timing
- Reset values: GEN_RESET=1, DATA=0, DATA_VALID=0, BUSY=0, SYNC_FOUND=0, TIMEOUT=0, OVERRUN=0, STATE=IDLE.
- All outputs are registered.
- ENABLE high in IDLE at edge n → STATE=HUNT and GEN_RESET=0 from cycle n+1.
- SAMP completing sync at edge n → SYNC_FOUND=1 and STATE=FRAME during cycle n+1 only.
- SAMP completing a byte at edge n → DATA_VALID=1 from cycle n+1.
- Transfer at edge n → DATA_VALID=0 at n+1, unless a new byte loaded at n.
- Timeout at edge n → TIMEOUT=1, STATE=IDLE, GEN_RESET=1 during cycle n+1.
- ABORT at edge n → IDLE at n+1.
- RESET_N low at an edge overrides everything, including mid-FRAME.

## Structure
- Package fsk_rx_pkg:
  - state encoding constants (IDLE/HUNT/FRAME/DRAIN);
  - default SYNC_WORD;
  - byte width constant 8.
- Sub-module fsk_sync_detector:
  - shift register, saturating hunt bit count and compare;
  - inputs: clear, SAMP, BIT_IN;
  - output: match.
- Top holds the FSM, counters and the output register.

## Test plan
- Reset: RESET_N=0 for 2 cycles, mid-FRAME → all outputs at reset values; GEN_RESET=1.
- Nominal: ENABLE=1, preamble 0x5555, then 0x2DD4, then payload 0xA5,0x3C,0x0F,0xF0; DATA_READY=1 → SYNC_FOUND one cycle after the 16th sync SAMP; four transfers in that order; then IDLE with GEN_RESET=1.
- Timeout: HUNT_TIMEOUT=40, alternating bits with no sync → TIMEOUT pulse one cycle after the 40th SAMP; STATE=IDLE; no DATA_VALID.
- Backpressure: DATA_READY=0 through the payload → DATA=0xA5 held, OVERRUN=1 after the 2nd byte; raising READY transfers 0xA5; DRAIN→IDLE.
- Abort: ABORT=1 after 3 payload bits → STATE=IDLE next cycle; DATA_VALID=0; GEN_RESET=1; no byte output.
- Simultaneous: new byte completes in the same cycle as a transfer → new byte loaded, DATA_VALID stays 1, OVERRUN stays 0.

Source files
------------

// File: rtl/fsk_rx_pkg.sv
// fsk_rx_pkg: state encoding and shared constants for the FSK receive sequencer
package fsk_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HUNT = 2'd1, FRAME = 2'd2, DRAIN = 2'd3} state_t;
  localparam logic [15:0] DEF_SYNC_WORD = 16'h2DD4;
  localparam int BYTE_W = 8;
endpackage

// File: rtl/fsk_sync_detector.sv
// fsk_sync_detector: shifts demodulated bits and flags a sync word match on the completing SAMP
// ports: CLOCK, RESET_N (sync, active-low), clear (restart hunt), samp/bit_in (bit strobe), match (combinational, same cycle as samp)
module fsk_sync_detector import fsk_rx_pkg::*; #(
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int SYNC_LEN = 16
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic clear,
  input  logic samp,
  input  logic bit_in,
  output logic match
);
  localparam int CW = $clog2(SYNC_LEN + 1);
  localparam logic [15:0] MASK = 16'((32'd1 << SYNC_LEN) - 32'd1);
  logic [14:0] sr;
  logic [15:0] sr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  // match looks at the post-shift window so the FSM can leave HUNT on the very SAMP that completes sync
  always_comb begin
    sr_nxt = {sr, bit_in};
    cnt_nxt = cnt == CW'(SYNC_LEN) ? cnt : cnt + CW'(1);
    match = samp && cnt_nxt == CW'(SYNC_LEN) && (sr_nxt & MASK) == (SYNC_WORD & MASK);
  end
  always_ff @(posedge CLOCK) begin
    if (!RESET_N || clear) begin
      sr <= '0;
      cnt <= '0;
    end else if (samp) begin
      sr <= sr_nxt[14:0];
      cnt <= cnt_nxt;
    end
  end
endmodule

// File: rtl/fsk_rx_sequencer.sv
// fsk_rx_sequencer: gates the sample clock generator, hunts for sync and frames payload bytes into a valid/ready register
// ports: CLOCK, RESET_N (sync, active-low), ENABLE, ABORT, SAMP, BIT_IN in; GEN_RESET, DATA, DATA_VALID out; DATA_READY in;
//        BUSY, SYNC_FOUND, TIMEOUT, OVERRUN (sticky), STATE out -- all outputs registered
module fsk_rx_sequencer import fsk_rx_pkg::*; #(
  parameter logic [15:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int SYNC_LEN = 16,
  parameter int PAYLOAD_BYTES = 4,
  parameter int HUNT_TIMEOUT = 1024
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic ENABLE,
  input  logic ABORT,
  input  logic SAMP,
  input  logic BIT_IN,
  output logic GEN_RESET,
  output logic [BYTE_W-1:0] DATA,
  output logic DATA_VALID,
  input  logic DATA_READY,
  output logic BUSY,
  output logic SYNC_FOUND,
  output logic TIMEOUT,
  output logic OVERRUN,
  output logic [1:0] STATE
);
  localparam int TW = HUNT_TIMEOUT > 0 ? $clog2(HUNT_TIMEOUT + 1) : 1;
  state_t state, nxt;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [TW-1:0] to_cnt;
  logic [BYTE_W-2:0] sh;
  logic start, hunt_samp, frame_samp, match, to_hit, byte_done, last_byte, xfer, load;
  fsk_sync_detector #(.SYNC_WORD(SYNC_WORD), .SYNC_LEN(SYNC_LEN)) u_det (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .clear(start), .samp(hunt_samp), .bit_in(BIT_IN), .match(match)
  );
  // ABORT masks every strobe so nothing is loaded or counted on the cycle it takes effect
  always_comb begin
    start = state == IDLE && ENABLE && !ABORT;
    hunt_samp = SAMP && state == HUNT && !ABORT;
    frame_samp = SAMP && state == FRAME && !ABORT;
    to_hit = hunt_samp && HUNT_TIMEOUT != 0 && int'(to_cnt) + 1 == HUNT_TIMEOUT;
    byte_done = frame_samp && bit_cnt == 3'd7;
    last_byte = byte_done && int'(byte_cnt) + 1 == PAYLOAD_BYTES;
    xfer = DATA_VALID && DATA_READY;
    load = byte_done && (!DATA_VALID || xfer);
    nxt = ABORT ? IDLE :
          state == IDLE  ? (ENABLE ? HUNT : IDLE) :
          state == HUNT  ? (match ? FRAME : to_hit ? IDLE : HUNT) :
          state == FRAME ? (last_byte ? DRAIN : FRAME) :
          (DATA_VALID ? DRAIN : IDLE);
  end
  always_ff @(posedge CLOCK) state <= RESET_N ? nxt : IDLE;
  assign STATE = state;
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      GEN_RESET <= 1'b1;
      BUSY <= 1'b0;
      SYNC_FOUND <= 1'b0;
      TIMEOUT <= 1'b0;
      OVERRUN <= 1'b0;
      DATA <= '0;
      DATA_VALID <= 1'b0;
      bit_cnt <= '0;
      byte_cnt <= '0;
      to_cnt <= '0;
      sh <= '0;
    end else begin
      GEN_RESET <= nxt == IDLE || nxt == DRAIN;
      BUSY <= nxt != IDLE;
      SYNC_FOUND <= match;
      TIMEOUT <= to_hit && !match;
      to_cnt <= start ? '0 : hunt_samp ? to_cnt + TW'(1) : to_cnt;
      bit_cnt <= match ? '0 : frame_samp ? bit_cnt + 3'd1 : bit_cnt;
      byte_cnt <= match ? '0 : byte_done ? byte_cnt + 8'd1 : byte_cnt;
      if (frame_samp) sh <= {sh[BYTE_W-3:0], BIT_IN};
      if (load) DATA <= {sh, BIT_IN};
      DATA_VALID <= ABORT && state != IDLE ? 1'b0 : load ? 1'b1 : xfer ? 1'b0 : DATA_VALID;
      OVERRUN <= start ? 1'b0 : OVERRUN | (byte_done && !load);
    end
  end
endmodule

// File: tb/tb_fsk_rx_sequencer.sv
// tb_fsk_rx_sequencer: directed checks of hunt, framing, backpressure, abort and reset behaviour
module tb_fsk_rx_sequencer;
  logic CLOCK = 1'b0, RESET_N = 1'b0, ENABLE = 1'b0, ABORT = 1'b0, SAMP = 1'b0, BIT_IN = 1'b0, DATA_READY = 1'b0;
  logic GEN_RESET, DATA_VALID, BUSY, SYNC_FOUND, TIMEOUT, OVERRUN;
  logic [7:0] DATA;
  logic [1:0] STATE;
  int n_tests = 0, n_fail = 0;
  fsk_rx_sequencer #(.HUNT_TIMEOUT(40)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .ENABLE(ENABLE), .ABORT(ABORT), .SAMP(SAMP), .BIT_IN(BIT_IN),
    .GEN_RESET(GEN_RESET), .DATA(DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .BUSY(BUSY), .SYNC_FOUND(SYNC_FOUND), .TIMEOUT(TIMEOUT), .OVERRUN(OVERRUN), .STATE(STATE)
  );
  always #5 CLOCK = ~CLOCK;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(negedge CLOCK);
  endtask
  task automatic send_bit(input logic b);
    SAMP = 1'b1;
    BIT_IN = b;
    tick();
    SAMP = 1'b0;
  endtask
  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask
  task automatic start_hunt(input string tag);
    ENABLE = 1'b1;
    tick();
    ENABLE = 1'b0;
    check({tag, "_state"}, 16'(STATE), 16'd1);
    check({tag, "_genrst"}, 16'(GEN_RESET), 16'd0);
    check({tag, "_ovr_clr"}, 16'(OVERRUN), 16'd0);
  endtask
  task automatic check_reset(input string tag);
    check({tag, "_genrst"}, 16'(GEN_RESET), 16'd1);
    check({tag, "_data"}, 16'(DATA), 16'h00);
    check({tag, "_valid"}, 16'(DATA_VALID), 16'd0);
    check({tag, "_busy"}, 16'(BUSY), 16'd0);
    check({tag, "_sync"}, 16'(SYNC_FOUND), 16'd0);
    check({tag, "_tmo"}, 16'(TIMEOUT), 16'd0);
    check({tag, "_ovr"}, 16'(OVERRUN), 16'd0);
    check({tag, "_state"}, 16'(STATE), 16'd0);
  endtask
  logic [7:0] payload [4] = '{8'hA5, 8'h3C, 8'h0F, 8'hF0};
  initial begin
    tick();
    tick();
    check_reset("rst0");
    RESET_N = 1'b1;
    tick();
    check("idle_state", 16'(STATE), 16'd0);
    // nominal reception with a ready consumer
    start_hunt("nom");
    send_bits(16'h5555, 16);
    send_bits(16'h2DD4 >> 1, 15);
    check("nom_sync_early", 16'(SYNC_FOUND), 16'd0);
    send_bit(1'b0);
    check("nom_sync", 16'(SYNC_FOUND), 16'd1);
    check("nom_frame", 16'(STATE), 16'd2);
    DATA_READY = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_bits(16'(payload[k]), 8);
      check($sformatf("nom_valid%0d", k), 16'(DATA_VALID), 16'd1);
      check($sformatf("nom_data%0d", k), 16'(DATA), 16'(payload[k]));
      if (k == 0) check("nom_sync_pulse", 16'(SYNC_FOUND), 16'd0);
    end
    check("nom_drain", 16'(STATE), 16'd3);
    check("nom_drain_genrst", 16'(GEN_RESET), 16'd1);
    tick();
    check("nom_xfer", 16'(DATA_VALID), 16'd0);
    tick();
    check("nom_idle", 16'(STATE), 16'd0);
    check("nom_idle_genrst", 16'(GEN_RESET), 16'd1);
    check("nom_idle_busy", 16'(BUSY), 16'd0);
    check("nom_ovr", 16'(OVERRUN), 16'd0);
    // hunt timeout after 40 SAMPs of alternating bits
    start_hunt("tmo");
    for (int i = 0; i < 39; i++) send_bit(1'(i % 2));
    check("tmo_early", 16'(TIMEOUT), 16'd0);
    check("tmo_early_state", 16'(STATE), 16'd1);
    send_bit(1'b1);
    check("tmo_pulse", 16'(TIMEOUT), 16'd1);
    check("tmo_state", 16'(STATE), 16'd0);
    check("tmo_genrst", 16'(GEN_RESET), 16'd1);
    check("tmo_valid", 16'(DATA_VALID), 16'd0);
    tick();
    check("tmo_pulse_end", 16'(TIMEOUT), 16'd0);
    // backpressure: consumer stalled for the whole payload
    DATA_READY = 1'b0;
    start_hunt("bp");
    send_bits(16'h2DD4, 16);
    check("bp_sync", 16'(SYNC_FOUND), 16'd1);
    send_bits(16'hA5, 8);
    check("bp_valid", 16'(DATA_VALID), 16'd1);
    check("bp_ovr0", 16'(OVERRUN), 16'd0);
    send_bits(16'h3C, 8);
    check("bp_data1", 16'(DATA), 16'hA5);
    check("bp_ovr1", 16'(OVERRUN), 16'd1);
    send_bits(16'h0F, 8);
    send_bits(16'hF0, 8);
    check("bp_drain", 16'(STATE), 16'd3);
    check("bp_data_held", 16'(DATA), 16'hA5);
    DATA_READY = 1'b1;
    tick();
    check("bp_xfer", 16'(DATA_VALID), 16'd0);
    tick();
    check("bp_idle", 16'(STATE), 16'd0);
    check("bp_ovr_sticky", 16'(OVERRUN), 16'd1);
    // new byte completes on the same edge as a transfer
    DATA_READY = 1'b0;
    start_hunt("sim");
    send_bits(16'h2DD4, 16);
    send_bits(16'hA5, 8);
    send_bits(16'h3C >> 1, 7);
    DATA_READY = 1'b1;
    send_bit(1'b0);
    DATA_READY = 1'b0;
    check("sim_valid", 16'(DATA_VALID), 16'd1);
    check("sim_data", 16'(DATA), 16'h3C);
    check("sim_ovr", 16'(OVERRUN), 16'd0);
    // abort with a byte still pending
    send_bits(16'h0F >> 3, 5);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("abp_state", 16'(STATE), 16'd0);
    check("abp_valid", 16'(DATA_VALID), 16'd0);
    // abort after 3 payload bits
    DATA_READY = 1'b1;
    start_hunt("ab");
    send_bits(16'h2DD4, 16);
    send_bits(16'h5, 3);
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("ab_state", 16'(STATE), 16'd0);
    check("ab_valid", 16'(DATA_VALID), 16'd0);
    check("ab_genrst", 16'(GEN_RESET), 16'd1);
    check("ab_busy", 16'(BUSY), 16'd0);
    tick();
    check("ab_no_byte", 16'(DATA_VALID), 16'd0);
    // reset in the middle of FRAME with a pending byte and overrun set
    DATA_READY = 1'b0;
    start_hunt("mr");
    send_bits(16'h2DD4, 16);
    send_bits(16'hA5, 8);
    send_bits(16'h3C, 8);
    send_bits(16'h5, 3);
    check("mr_pre_ovr", 16'(OVERRUN), 16'd1);
    RESET_N = 1'b0;
    tick();
    tick();
    check_reset("mr");
    RESET_N = 1'b1;
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
